serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 17 +
 rtl/serial_add_sub_if.sv | 36 +++
 rtl/serial_add_sub_bit_cell.sv | 17 +
 rtl/serial_add_sub.sv | 130 +++++++++++++
 tb/tb_serial_add_sub.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared types and constants for the bit-serial adder/subtractor
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - operand/result handshake bundle; ovf only with SERIAL_ADD_SUB_OVF_EN
interface serial_add_sub_if #(parameter int WIDTH = 8);

   logic             start_valid;
   logic             start_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] result;
   logic             flag;
   logic             busy;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start_valid, op, a, b, res_ready,
      input  start_ready, res_valid, result, flag, busy, ovf
   );
   modport slave (
      input  start_valid, op, a, b, res_ready,
      output start_ready, res_valid, result, flag, busy, ovf
   );
`else
   modport master (
      output start_valid, op, a, b, res_ready,
      input  start_ready, res_valid, result, flag, busy
   );
   modport slave (
      input  start_valid, op, a, b, res_ready,
      output start_ready, res_valid, result, flag, busy
   );
`endif

endinterface

// File: rtl/serial_add_sub_bit_cell.sv
// rtl/serial_add_sub_bit_cell.sv - combinational one-bit full adder / full subtractor
module serial_bit_cell
   import serial_arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic op,
   output logic y,
   output logic cout
);

   assign y    = a ^ b ^ cin;
   assign cout = (op == OP_SUB) ? ((~a & b) | (~(a ^ b) & cin))
                                : ((a & b) | (cin & (a ^ b)));

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial add/sub, one bit per clock LSB first
// Optional signed-overflow output enabled by SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic clk,
   input  logic rst_n,
   serial_add_sub_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             op_q, op_d;
   logic             flag_q, flag_d;
   logic             cell_y, cell_cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   serial_bit_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (c_q),
      .op   (op_q),
      .y    (cell_y),
      .cout (cell_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sr_d     = sr_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      op_d     = op_q;
      flag_d   = flag_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = bus.op;
               c_d     = 1'b0;
               cnt_d   = '0;
               sr_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sr_d  = {cell_y, sr_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = cell_cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               result_d = {cell_y, sr_q[WIDTH-1:1]};
               flag_d   = cell_cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
               // On the last bit a_q[0]/b_q[0] hold the operand MSBs and cell_y is the result MSB.
               if (op_q == OP_ADD)
                  ovf_d = (a_q[0] == b_q[0]) && (cell_y != a_q[0]);
               else
                  ovf_d = (a_q[0] != b_q[0]) && (cell_y != a_q[0]);
`endif
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sr_q     <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         c_q      <= 1'b0;
         op_q     <= OP_ADD;
         flag_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sr_q     <= sr_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         c_q      <= c_d;
         op_q     <= op_d;
         flag_q   <= flag_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.result      = result_q;
   assign bus.flag        = flag_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
   assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub (SERIAL_ADD_SUB_OVF_EN aware)
module tb_serial_add_sub;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] r;
      logic         f;
      logic         v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   serial_add_sub_if #(.WIDTH(W)) bus ();

   serial_add_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Plain-integer reference: full-precision sum/difference and signed range test.
   function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ux = x;
      longint uy = y;
      longint sx = $signed(x);
      longint sy = $signed(y);
      longint u;
      longint s;
      u   = o ? ux - uy : ux + uy;
      s   = o ? sx - sy : sx + sy;
      e.r = u[W-1:0];
      e.f = o ? (u < 0) : (u >= (longint'(1) << W));
      e.v = (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_vs_busy", {31'b0, bus.start_ready}, {31'b0, ~bus.busy});
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               chk("cmp_result", {24'b0, bus.result}, {24'b0, exp_q[0].r});
               chk("cmp_flag", {31'b0, bus.flag}, {31'b0, exp_q[0].f});
`ifdef SERIAL_ADD_SUB_OVF_EN
               chk("cmp_ovf", {31'b0, bus.ovf}, {31'b0, exp_q[0].v});
`endif
               if (bus.res_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(negedge clk);
      bus.op = o; bus.a = x; bus.b = y; bus.start_valid = 1'b1;
      while (!bus.start_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", {31'b0, bus.start_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back(model(o, x, y));
      #1;
      bus.start_valid = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.op = ~o;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.res_valid && n < 100);
      chk(nm, n, W);
   endtask

   task automatic release_res();
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      chk("post_hs_ready", {31'b0, bus.start_ready}, 32'd1);
      chk("post_hs_valid", {31'b0, bus.res_valid}, 32'd0);
   endtask

   task automatic run_op(input string nm, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ef);
      start_op(o, x, y);
      wait_done({nm, "_latency"});
      chk({nm, "_res"}, {24'b0, bus.result}, {24'b0, er});
      chk({nm, "_flag"}, {31'b0, bus.flag}, {31'b0, ef});
      release_res();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      exp_t         m;
      logic [W-1:0] held_r;
      logic         held_f;

      bus.start_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.res_ready = 1'b0;

      m = model(1'b0, 8'h35, 8'h4A);
      chk("pin_add", {23'b0, m.f, m.r}, 32'h07F);
      m = model(1'b1, 8'h00, 8'h01);
      chk("pin_sub", {23'b0, m.f, m.r}, 32'h1FF);
      m = model(1'b0, 8'h7F, 8'h01);
      chk("pin_ovf_add", {31'b0, m.v}, 32'd1);
      m = model(1'b1, 8'h80, 8'h01);
      chk("pin_ovf_sub", {23'b0, m.v, m.r}, 32'h17F);

      #12;
      chk("rst_ready", {31'b0, bus.start_ready}, 32'd1);
      chk("rst_valid", {31'b0, bus.res_valid}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_result", {24'b0, bus.result}, 32'd0);
      chk("rst_flag", {31'b0, bus.flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_35_4a", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0);
      run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
      run_op("sub_10_01", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0);
      run_op("sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1);

      // Back-to-back with res_ready held high.
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.op = 1'b0; bus.a = 8'h12; bus.b = 8'h34; bus.start_valid = 1'b1;
      chk("b2b_ready1", {31'b0, bus.start_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back(model(1'b0, 8'h12, 8'h34));
      #1;
      bus.op = 1'b1; bus.a = 8'h50; bus.b = 8'h60;
      wait_done("b2b_lat1");
      chk("b2b_res1", {24'b0, bus.result}, 32'h46);
      @(posedge clk);
      #1;
      chk("b2b_ready_after_hs", {31'b0, bus.start_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back(model(1'b1, 8'h50, 8'h60));
      #1;
      chk("b2b_busy2", {31'b0, bus.busy}, 32'd1);
      bus.start_valid = 1'b0;
      wait_done("b2b_lat2");
      chk("b2b_res2", {24'b0, bus.result}, 32'hF0);
      chk("b2b_flag2", {31'b0, bus.flag}, 32'd1);
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;

      // Backpressure: hold DONE and poke start_valid.
      start_op(1'b1, 8'h00, 8'h01);
      wait_done("bp_latency");
      held_r = bus.result;
      held_f = bus.flag;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.start_valid = ~i[0];
         bus.a = 8'h11; bus.b = 8'h22; bus.op = 1'b0;
         chk("bp_result", {24'b0, bus.result}, {24'b0, held_r});
         chk("bp_flag", {31'b0, bus.flag}, {31'b0, held_f});
         chk("bp_start_ready", {31'b0, bus.start_ready}, 32'd0);
         chk("bp_valid", {31'b0, bus.res_valid}, 32'd1);
      end
      @(negedge clk);
      bus.start_valid = 1'b0;
      @(posedge clk);
      #1;
      release_res();
      @(posedge clk);
      #1;
      chk("bp_no_ghost_op", {31'b0, bus.busy}, 32'd0);

      // Reset during the third RUN cycle.
      start_op(1'b0, 8'hAA, 8'h55);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_ready", {31'b0, bus.start_ready}, 32'd1);
      chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("mid_rst_valid", {31'b0, bus.res_valid}, 32'd0);
      chk("mid_rst_result", {24'b0, bus.result}, 32'd0);
      chk("mid_rst_flag", {31'b0, bus.flag}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_add", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0);

`ifdef SERIAL_ADD_SUB_OVF_EN
      run_op("ovf_add_7f", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0);
      chk("ovf_add_7f_ovf", {31'b0, bus.ovf}, 32'd1);
      run_op("ovf_sub_80", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0);
      chk("ovf_sub_80_ovf", {31'b0, bus.ovf}, 32'd1);
      run_op("ovf_add_05", 1'b0, 8'h05, 8'h03, 8'h08, 1'b0);
      chk("ovf_add_05_ovf", {31'b0, bus.ovf}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
